// File: rtl/spram_arbiter_pkg.sv
// spram_arbiter_pkg: shared widths and encodings for the SPRAM frame-store arbiter
package spram_arbiter_pkg;
  localparam int SPRAM_AW = 15;
  localparam int SPRAM_DW = 12;
  localparam int ROW_W = 8;
  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {SLOT_NONE, SLOT_RD, SLOT_WR} slot_t;
endpackage

// File: rtl/spram_rd_return.sv
// spram_rd_return: captures SPRAM read data the cycle after issue and presents it registered with column and done
module spram_rd_return
  import spram_arbiter_pkg::*;
#(
  parameter int W = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_rd,
  input  logic [ROW_W-1:0]    iss_col,
  input  logic [SPRAM_DW-1:0] spram_rd_data,
  output logic                last,
  output logic                rd_valid,
  output logic [SPRAM_DW-1:0] rd_data,
  output logic [ROW_W-1:0]    rd_col,
  output logic                rd_done
);
  logic                cap_valid;
  logic [SPRAM_DW-1:0] cap_data;
  logic [ROW_W-1:0]    cap_col;
  assign last = cap_valid && cap_col == ROW_W'(W - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_col   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_col    <= '0;
      rd_done   <= 1'b0;
    end else begin
      cap_valid <= iss_rd;
      cap_data  <= spram_rd_data;
      cap_col   <= iss_col;
      rd_valid  <= cap_valid;
      rd_data   <= cap_data;
      rd_col    <= cap_col;
      rd_done   <= last;
    end
endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one SPRAM between pixel writes and row-burst reads with write anti-starvation
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int W            = 50,
  parameter int H            = 40,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_req,
  input  logic [SPRAM_AW-1:0] wr_addr,
  input  logic [SPRAM_DW-1:0] wr_data,
  output logic                wr_ack,
  output logic                wr_err,
  input  logic                rd_start,
  input  logic [ROW_W-1:0]    rd_row,
  output logic                rd_busy,
  output logic                rd_err,
  output logic                rd_valid,
  output logic [SPRAM_DW-1:0] rd_data,
  output logic [ROW_W-1:0]    rd_col,
  output logic                rd_done,
  output logic [SPRAM_AW-1:0] spram_addr,
  output logic [SPRAM_DW-1:0] spram_wr_data,
  output logic                spram_wre,
  output logic                spram_ce,
  input  logic [SPRAM_DW-1:0] spram_rd_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SPRAM_AW:0] DEPTH = (SPRAM_AW + 1)'(W * H);
  if (W < 1 || W > 255 || H < 1 || H > 255 || W * H > 32768 || STARVE_LIMIT < 1) begin : g_param_check
    $error("spram_arbiter: W/H/STARVE_LIMIT out of range");
  end
  state_t              state, state_nx;
  slot_t               slot;
  logic [SPRAM_AW-1:0] base;
  logic [ROW_W-1:0]    issue_col, iss_col;
  logic [CW-1:0]       run_cnt;
  logic                iss_rd, last, wr_pend, wr_bad, rd_ok, issuing, wr_go;
  // a request still high while its ack is visible belongs to the previous slot
  assign wr_pend = wr_req && !wr_ack;
  assign wr_bad  = {1'b0, wr_addr} >= DEPTH;
  assign rd_ok   = rd_start && state == IDLE && rd_row < ROW_W'(H);
  assign issuing = state == BURST && issue_col != ROW_W'(W);
  assign wr_go   = slot == SLOT_WR && !wr_bad;
  assign rd_busy = state == BURST;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (rd_ok ? BURST : IDLE) : (last ? IDLE : BURST);
  always_comb
    slot = state == IDLE ? ((!rd_ok && wr_pend) ? SLOT_WR : SLOT_NONE)
         : !issuing ? SLOT_NONE
         : (wr_pend && run_cnt == CW'(STARVE_LIMIT)) ? SLOT_WR : SLOT_RD;
  always_ff @(posedge clk)
    if (!rst_n) begin
      spram_addr    <= '0;
      spram_wr_data <= '0;
      spram_wre     <= 1'b0;
      spram_ce      <= 1'b0;
      wr_ack        <= 1'b0;
      wr_err        <= 1'b0;
      rd_err        <= 1'b0;
      base          <= '0;
      issue_col     <= '0;
      run_cnt       <= '0;
      iss_rd        <= 1'b0;
      iss_col       <= '0;
    end else begin
      spram_ce  <= slot == SLOT_RD || wr_go;
      spram_wre <= wr_go;
      if (slot == SLOT_RD) spram_addr <= base + SPRAM_AW'(issue_col);
      else if (wr_go) spram_addr <= wr_addr;
      if (wr_go) spram_wr_data <= wr_data;
      wr_ack  <= slot == SLOT_WR;
      wr_err  <= slot == SLOT_WR && wr_bad;
      rd_err  <= rd_start && !rd_ok;
      if (rd_ok) base <= SPRAM_AW'(rd_row) * SPRAM_AW'(W);
      issue_col <= rd_ok ? '0 : slot == SLOT_RD ? issue_col + 1'b1 : issue_col;
      run_cnt   <= (!wr_req || slot == SLOT_WR) ? '0 : slot == SLOT_RD ? run_cnt + 1'b1 : run_cnt;
      iss_rd    <= slot == SLOT_RD;
      iss_col   <= issue_col;
    end
  spram_rd_return #(.W(W)) u_ret (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_rd       (iss_rd),
    .iss_col      (iss_col),
    .spram_rd_data(spram_rd_data),
    .last         (last),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_col       (rd_col),
    .rd_done      (rd_done)
  );
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: scoreboard bench for spram_arbiter with a behavioural SPRAM
module tb_spram_arbiter;
  localparam int W = 50;
  typedef struct packed {
    logic [11:0] data;
    logic [7:0]  col;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_start = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic [7:0]  rd_row = '0;
  logic        wr_ack, wr_err, rd_busy, rd_err, rd_valid, rd_done, spram_wre, spram_ce;
  logic [11:0] rd_data, spram_wr_data, spram_rd_data;
  logic [7:0]  rd_col;
  logic [14:0] spram_addr;
  logic [11:0] mem [32768];
  logic        loaded = 1'b0;
  exp_t        sq[$];
  exp_t        e;
  int n_tests = 0, n_fail = 0;
  int n_ce = 0, n_rd = 0, n_gap = 0, n_done = 0;
  int rd0, ce0, g0, d0, ack_reads;
  logic        ack_wre, seen_first = 1'b0;
  logic [14:0] ack_addr;

  spram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_start(rd_start), .rd_row(rd_row),
    .rd_busy(rd_busy), .rd_err(rd_err), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_col(rd_col), .rd_done(rd_done), .spram_addr(spram_addr),
    .spram_wr_data(spram_wr_data), .spram_wre(spram_wre), .spram_ce(spram_ce),
    .spram_rd_data(spram_rd_data)
  );

  always #5 clk = ~clk;

  assign spram_rd_data = mem[spram_addr];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 32768; k++) mem[k] <= 12'(k);
      loaded <= 1'b1;
    end else if (spram_ce && spram_wre) mem[spram_addr] <= spram_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (spram_ce) n_ce++;
    if (spram_ce && !spram_wre) n_rd++;
    if (rd_done) n_done++;
    if (rd_done && !rd_valid) check("done_without_valid", 32'(rd_valid), 32'd1);
    if (rd_valid) begin
      if (sq.size() == 0) check("unexpected_valid", 32'(sq.size()), 32'd1);
      else begin
        e = sq.pop_front();
        check("rd_data", 32'(rd_data), 32'(e.data));
        check("rd_col", 32'(rd_col), 32'(e.col));
        check("rd_done", 32'(rd_done), 32'(e.col == 8'(W - 1)));
      end
    end
    if (!rd_busy) seen_first = 1'b0;
    else if (rd_valid) seen_first = 1'b1;
    else if (seen_first) n_gap++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input int row);
    rd_start = 1'b1;
    rd_row = 8'(row);
    for (int c = 0; c < W; c++) sq.push_back({12'(row * W + c), 8'(c)});
    tick;
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      tick;
      n++;
      if (wr_ack && wr_req) begin
        ack_reads = n_rd - rd0;
        ack_wre = spram_wre;
        ack_addr = spram_addr;
        wr_req = 1'b0;
      end
    end while (rd_busy && n < 300);
    if (rd_busy) check({tag, "_timeout"}, 32'(rd_busy), 32'd0);
    tick;
  endtask

  initial begin
    // reset with a pending write
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 12'h001;
    repeat (2) tick;
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_ce", 32'(spram_ce), 0);
    check("rst_wre", 32'(spram_wre), 0);
    check("rst_addr", 32'(spram_addr), 0);
    check("rst_busy", 32'(rd_busy), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_done", 32'(rd_done), 0);
    check("rst_errs", {30'd0, wr_err, rd_err}, 0);
    wr_req = 1'b0;
    rst_n = 1'b1;
    tick;
    // single write
    wr_req = 1'b1; wr_addr = 15'h0007; wr_data = 12'hABC;
    tick;
    check("wr_addr", 32'(spram_addr), 32'h7);
    check("wr_data", 32'(spram_wr_data), 32'hABC);
    check("wr_wre", 32'(spram_wre), 1);
    check("wr_ce", 32'(spram_ce), 1);
    check("wr_ack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    tick;
    check("wr_ack_pulse", 32'(wr_ack), 0);
    check("wr_ce_idle", 32'(spram_ce), 0);
    // plain row burst
    g0 = n_gap; d0 = n_done; ce0 = n_ce;
    start_row(2);
    check("burst_busy", 32'(rd_busy), 1);
    check("burst_no_issue_yet", 32'(spram_ce), 0);
    tick;
    check("burst_first_addr", 32'(spram_addr), 100);
    check("burst_first_rd", {30'd0, spram_ce, spram_wre}, 32'b10);
    wait_idle("burst");
    check("burst_done_cnt", 32'(n_done - d0), 1);
    check("burst_gaps", 32'(n_gap - g0), 0);
    check("burst_issues", 32'(n_ce - ce0), W);
    check("burst_sq_empty", 32'(sq.size()), 0);
    // contention: write held from burst start, requester drops on ack
    g0 = n_gap; d0 = n_done; ce0 = n_ce; rd0 = n_rd; ack_reads = -1;
    wr_req = 1'b1; wr_addr = 15'd1000; wr_data = 12'h5A5;
    start_row(2);
    check("arb_read_wins", 32'(wr_ack), 0);
    wait_idle("contend");
    check("starve_reads", 32'(ack_reads), 8);
    check("starve_wre", 32'(ack_wre), 1);
    check("starve_addr", 32'(ack_addr), 1000);
    check("contend_issues", 32'(n_ce - ce0), W + 1);
    check("contend_gaps", 32'(n_gap - g0), 1);
    check("contend_done_cnt", 32'(n_done - d0), 1);
    check("contend_sq_empty", 32'(sq.size()), 0);
    check("contend_mem", 32'(mem[1000]), 32'h5A5);
    // rejected requests
    d0 = n_done;
    start_row(2);
    rd_start = 1'b1; rd_row = 8'd5;
    tick;
    check("err_busy_start", 32'(rd_err), 1);
    rd_start = 1'b0;
    tick;
    check("err_pulse", 32'(rd_err), 0);
    wait_idle("err_burst");
    check("err_burst_done", 32'(n_done - d0), 1);
    check("err_burst_sq", 32'(sq.size()), 0);
    rd_start = 1'b1; rd_row = 8'd40;
    tick;
    check("err_row40", 32'(rd_err), 1);
    check("err_row40_busy", 32'(rd_busy), 0);
    rd_start = 1'b0;
    ce0 = n_ce;
    wr_req = 1'b1; wr_addr = 15'd2000; wr_data = 12'hFFF;
    tick;
    check("bad_wr_ack", {30'd0, wr_ack, wr_err}, 32'b11);
    check("bad_wr_ce", 32'(spram_ce), 0);
    wr_req = 1'b0;
    tick;
    check("bad_wr_pulse", {30'd0, wr_ack, wr_err}, 0);
    check("bad_wr_no_access", 32'(n_ce - ce0), 0);
    // reset mid-burst
    d0 = n_done;
    start_row(3);
    for (int n = 0; n < 100 && !(rd_valid && rd_col == 8'd20); n++) tick;
    check("mid_reached_col20", 32'(rd_col), 20);
    rst_n = 1'b0;
    tick;
    check("mid_rst_busy", 32'(rd_busy), 0);
    check("mid_rst_out", {29'd0, rd_valid, rd_done, spram_ce}, 0);
    sq.delete();
    rst_n = 1'b1;
    tick;
    check("mid_no_done", 32'(n_done - d0), 0);
    start_row(5);
    tick;
    check("mid_new_base", 32'(spram_addr), 250);
    wait_idle("mid_new");
    check("mid_new_done", 32'(n_done - d0), 1);
    check("mid_new_sq", 32'(sq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
